mac_rx_fifo_wr_ctrl: RTL and testbench

- Write-side controller for the MAC receive packet FIFO.
- Takes the byte stream from the MAC receive path and packs 4 bytes into one 36-bit word: 32 data bits plus a 4-bit tag.
- Drives port A of the 36-bit dual-port RAM directly below it.
- Commits whole good packets to the reader; rewinds bad or overflowing packets so the reader never sees them.

---
 rtl/mac_rx_fifo_wr_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mac_rx_fifo_wr_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx_fifo_wr_ctrl.sv
// mac_rx_fifo_wr_ctrl
// Write-side controller for the MAC receive packet FIFO. Packs the received
// byte stream four bytes at a time into 36-bit words (32 data bits + 4-bit
// tag) and writes them through port A of the dual-port RAM below. Good
// packets are committed to the reader by advancing Commit_ptr; bad packets
// and packets that run out of space are rewound so the reader never sees them.
//
// Ports:
//   Clk, Reset        clock, asynchronous active-high reset
//   Rx_data[7:0]      received byte, valid when Rx_data_en
//   Rx_data_end       last byte of the packet (qualified by Rx_data_en)
//   Rx_data_err       bad packet, sampled with Rx_data_end
//   Rd_ptr            reader's next read address
//   Wr_data[35:0]     RAM write data {tag[3:0], data[31:0]}
//   Wr_en, Wr_addr    RAM write strobe and address
//   Commit_ptr        one past the last word of the last committed packet
//   Pkt_commit        one-cycle pulse per committed packet
//   Pkt_drop          one-cycle pulse per discarded packet
//   Full              no free word left (one slot is always kept empty)
//   Drop_cnt          saturating count of dropped packets
//
// Handshake: the byte interface has no back-pressure. A byte is consumed in
// every cycle Rx_data_en is high; Rx_data_end/Rx_data_err are only looked at
// in such cycles. The RAM write happens in every cycle Wr_en is high, at
// Wr_addr, with Wr_data.
//
// Tag format: [35] end of packet, [34] 0, [33:32] valid bytes - 1 (only
// meaningful when [35] is set, otherwise the whole tag is 0).

module mac_rx_fifo_wr_ctrl #(
  parameter int ADDR_WIDTH     = 9,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [7:0]                Rx_data,
  input  logic                      Rx_data_en,
  input  logic                      Rx_data_end,
  input  logic                      Rx_data_err,
  input  logic [ADDR_WIDTH-1:0]     Rd_ptr,
  output logic [35:0]               Wr_data,
  output logic                      Wr_en,
  output logic [ADDR_WIDTH-1:0]     Wr_addr,
  output logic [ADDR_WIDTH-1:0]     Commit_ptr,
  output logic                      Pkt_commit,
  output logic                      Pkt_drop,
  output logic                      Full,
  output logic [DROP_CNT_WIDTH-1:0] Drop_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PACK = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  localparam logic [ADDR_WIDTH-1:0]     ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DROP_CNT_WIDTH-1:0] CNT_ONE  = {{(DROP_CNT_WIDTH-1){1'b0}}, 1'b1};

  // state is left as a plainly named register so checkers can bind to it.
  logic [1:0]  state, state_d;
  logic [1:0]  lane, lane_d;
  // Bytes already collected for the current word; [23:16] is lane 0.
  logic [23:0] buf_q, buf_d;

  logic [ADDR_WIDTH-1:0] base_addr;    // address the next decided write lands on
  logic [ADDR_WIDTH-1:0] commit_base;  // Commit_ptr including a commit in flight
  logic [ADDR_WIDTH-1:0] free_now;
  logic [ADDR_WIDTH-1:0] free_next;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic                  full_now;

  logic [1:0]  eff_lane;
  logic [31:0] word;
  logic        accept;
  logic        word_due;

  logic        wr_en_d, commit_d, drop_d, rewind;
  logic [35:0] wr_data_d;

  // A write issued this cycle (Wr_en high) has not yet advanced Wr_addr, so
  // the next write goes one past it. Likewise a commit pulsing this cycle has
  // not yet moved Commit_ptr; a rewind decided now must use the new value.
  assign base_addr   = Wr_en ? (Wr_addr + ADDR_ONE) : Wr_addr;
  assign commit_base = Pkt_commit ? (Wr_addr + ADDR_ONE) : Commit_ptr;
  assign free_now    = Rd_ptr - base_addr - ADDR_ONE;
  assign full_now    = (free_now == '0);

  assign accept   = Rx_data_en && ((state == IDLE) || (state == PACK));
  assign eff_lane = (state == IDLE) ? 2'd0 : lane;
  assign word_due = Rx_data_end || (eff_lane == 2'd3);

  // Current word with the incoming byte dropped into its lane; lanes after
  // it are still zero because buf_q is cleared after every word.
  always_comb begin
    word = {buf_q, 8'h00};
    case (eff_lane)
      2'd0:    word[31:24] = Rx_data;
      2'd1:    word[23:16] = Rx_data;
      2'd2:    word[15:8]  = Rx_data;
      default: word[7:0]   = Rx_data;
    endcase
  end

  always_comb begin
    state_d   = state;
    lane_d    = lane;
    buf_d     = buf_q;
    wr_en_d   = 1'b0;
    wr_data_d = Wr_data;
    commit_d  = 1'b0;
    drop_d    = 1'b0;
    rewind    = 1'b0;

    if (accept) begin
      if (Rx_data_end && Rx_data_err) begin
        // Bad packet: discard everything written since the last commit.
        rewind  = 1'b1;
        drop_d  = 1'b1;
        state_d = IDLE;
        lane_d  = 2'd0;
        buf_d   = '0;
      end else if (word_due && full_now) begin
        rewind = 1'b1;
        lane_d = 2'd0;
        buf_d  = '0;
        if (Rx_data_end) begin
          drop_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = DROP;
        end
      end else if (word_due) begin
        wr_en_d   = 1'b1;
        wr_data_d = Rx_data_end ? {1'b1, 1'b0, eff_lane, word} : {4'b0000, word};
        lane_d    = 2'd0;
        buf_d     = '0;
        if (Rx_data_end) begin
          commit_d = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = PACK;
        end
      end else begin
        buf_d   = word[31:8];
        lane_d  = eff_lane + 2'd1;
        state_d = PACK;
      end
    end else if ((state == DROP) && Rx_data_en && Rx_data_end) begin
      drop_d  = 1'b1;
      state_d = IDLE;
      lane_d  = 2'd0;
    end
  end

  assign wr_addr_d = rewind ? commit_base : base_addr;
  // Full is registered against the Rd_ptr seen this cycle; a reader advance
  // shows up in Full one cycle later, while the write decision itself always
  // uses the live Rd_ptr.
  assign free_next = Rd_ptr - wr_addr_d - ADDR_ONE;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      lane       <= 2'd0;
      buf_q      <= '0;
      Wr_data    <= '0;
      Wr_en      <= 1'b0;
      Wr_addr    <= '0;
      Commit_ptr <= '0;
      Pkt_commit <= 1'b0;
      Pkt_drop   <= 1'b0;
      Full       <= 1'b0;
      Drop_cnt   <= '0;
    end else begin
      state      <= state_d;
      lane       <= lane_d;
      buf_q      <= buf_d;
      Wr_data    <= wr_data_d;
      Wr_en      <= wr_en_d;
      Wr_addr    <= wr_addr_d;
      Commit_ptr <= commit_base;
      Pkt_commit <= commit_d;
      Pkt_drop   <= drop_d;
      Full       <= (free_next == '0);
      if (drop_d && (Drop_cnt != '1)) begin
        Drop_cnt <= Drop_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_mac_rx_fifo_wr_ctrl.sv
module tb_mac_rx_fifo_wr_ctrl;

  localparam int AW = 3;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic          Clk = 1'b0;
  logic          Reset;
  logic [7:0]    Rx_data;
  logic          Rx_data_en;
  logic          Rx_data_end;
  logic          Rx_data_err;
  logic [AW-1:0] Rd_ptr;
  logic [35:0]   Wr_data;
  logic          Wr_en;
  logic [AW-1:0] Wr_addr;
  logic [AW-1:0] Commit_ptr;
  logic          Pkt_commit;
  logic          Pkt_drop;
  logic          Full;
  logic [DW-1:0] Drop_cnt;

  always #5 Clk = ~Clk;

  mac_rx_fifo_wr_ctrl #(.ADDR_WIDTH(AW), .DROP_CNT_WIDTH(DW)) dut (
    .Clk(Clk), .Reset(Reset),
    .Rx_data(Rx_data), .Rx_data_en(Rx_data_en), .Rx_data_end(Rx_data_end),
    .Rx_data_err(Rx_data_err), .Rd_ptr(Rd_ptr),
    .Wr_data(Wr_data), .Wr_en(Wr_en), .Wr_addr(Wr_addr),
    .Commit_ptr(Commit_ptr), .Pkt_commit(Pkt_commit), .Pkt_drop(Pkt_drop),
    .Full(Full), .Drop_cnt(Drop_cnt)
  );

  // ---------------- scoreboard ----------------
  // Expected RAM writes: {addr, data}. Expected packet events: 1 commit, 2 drop.
  logic [AW+35:0] exp_q[$];
  logic [1:0]     exp_ev_q[$];
  int n_vec = 0;
  int n_err = 0;
  logic saw_full;
  int   commit_run;
  int   max_commit_run;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [35:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: pops the expected queues whenever the DUT presents a write or a
  // packet event.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (Wr_en) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_wr: got addr %0h data %0h expected none", Wr_addr, Wr_data);
        end else begin
          logic [AW+35:0] e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(Wr_addr), 64'(e[AW+35:36]));
          check("wr_data", 64'(Wr_data), 64'(e[35:0]));
        end
      end
      if (Pkt_commit || Pkt_drop) begin
        if (exp_ev_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_event: got %0h expected none", {Pkt_drop, Pkt_commit});
        end else begin
          logic [1:0] ev;
          ev = exp_ev_q.pop_front();
          check("pkt_event", 64'({Pkt_drop, Pkt_commit}), 64'(ev));
        end
      end
      if (Full) saw_full = 1'b1;
      if (Pkt_commit) commit_run++;
      else commit_run = 0;
      if (commit_run > max_commit_run) max_commit_run = commit_run;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic e, input logic r);
    @(negedge Clk);
    Rx_data     = b;
    Rx_data_en  = 1'b1;
    Rx_data_end = e;
    Rx_data_err = r;
  endtask

  task automatic idle(input int n);
    @(negedge Clk);
    Rx_data_en  = 1'b0;
    Rx_data_end = 1'b0;
    Rx_data_err = 1'b0;
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset      = 1'b1;
    Rx_data_en = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset = 1'b1; Rx_data = '0; Rx_data_en = 1'b0; Rx_data_end = 1'b0;
    Rx_data_err = 1'b0; Rd_ptr = '0;
    saw_full = 1'b0; commit_run = 0; max_commit_run = 0;
    repeat (2) @(negedge Clk);
    check("rst_wr_en", 64'(Wr_en), 64'(0));
    check("rst_wr_addr", 64'(Wr_addr), 64'(0));
    check("rst_commit_ptr", 64'(Commit_ptr), 64'(0));
    check("rst_full", 64'(Full), 64'(0));
    check("rst_drop_cnt", 64'(Drop_cnt), 64'(0));
    check("rst_wr_data", 64'(Wr_data), 64'(0));
    Reset = 1'b0;

    // Good 5-byte packet.
    push_wr(3'd0, 36'h0_11223344);
    push_wr(3'd1, 36'h8_55000000);
    exp_ev_q.push_back(2'd1);
    send_byte(8'h11, 0, 0); send_byte(8'h22, 0, 0); send_byte(8'h33, 0, 0);
    send_byte(8'h44, 0, 0); send_byte(8'h55, 1, 0);
    idle(3);
    check("t1_commit_ptr", 64'(Commit_ptr), 64'(2));
    check("t1_wr_addr", 64'(Wr_addr), 64'(2));
    check("t1_drop_cnt", 64'(Drop_cnt), 64'(0));

    // Good 4-byte packet, then a 6-byte packet with error, then good 3-byte.
    do_reset();
    push_wr(3'd0, 36'hB_01020304);
    exp_ev_q.push_back(2'd1);
    send_byte(8'h01, 0, 0); send_byte(8'h02, 0, 0);
    send_byte(8'h03, 0, 0); send_byte(8'h04, 1, 0);
    push_wr(3'd1, 36'h0_10111213);
    exp_ev_q.push_back(2'd2);
    send_byte(8'h10, 0, 0); send_byte(8'h11, 0, 0); send_byte(8'h12, 0, 0);
    send_byte(8'h13, 0, 0); send_byte(8'h14, 0, 0); send_byte(8'h15, 1, 1);
    idle(3);
    check("t2_commit_ptr", 64'(Commit_ptr), 64'(1));
    check("t2_wr_addr", 64'(Wr_addr), 64'(1));
    check("t2_drop_cnt", 64'(Drop_cnt), 64'(1));
    push_wr(3'd1, 36'hA_20212200);
    exp_ev_q.push_back(2'd1);
    send_byte(8'h20, 0, 0); send_byte(8'h21, 0, 0); send_byte(8'h22, 1, 0);
    idle(3);
    check("t2_commit_ptr2", 64'(Commit_ptr), 64'(2));

    // Overflow: 40-byte packet, reader parked at 0, 7 words fit.
    do_reset();
    Rd_ptr = '0;
    saw_full = 1'b0;
    for (int w = 0; w < 7; w++)
      push_wr(3'(w), {4'h0, 8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)});
    exp_ev_q.push_back(2'd2);
    for (int i = 0; i < 40; i++) begin
      if (i == 36) check("t3_state_drop", 64'(dut.state), 64'(2));
      send_byte(8'(i), (i == 39), 1'b0);
    end
    idle(3);
    check("t3_saw_full", 64'(saw_full), 64'(1));
    check("t3_wr_addr", 64'(Wr_addr), 64'(0));
    check("t3_commit_ptr", 64'(Commit_ptr), 64'(0));
    check("t3_drop_cnt", 64'(Drop_cnt), 64'(1));
    check("t3_full_after", 64'(Full), 64'(0));

    // Wrap: fill 6 words, reader catches up to 6, 12-byte packet straddles.
    do_reset();
    for (int w = 0; w < 6; w++)
      push_wr(3'(w), {((w == 5) ? 4'hB : 4'h0),
                      8'(8'h80 + 4*w), 8'(8'h81 + 4*w), 8'(8'h82 + 4*w), 8'(8'h83 + 4*w)});
    exp_ev_q.push_back(2'd1);
    for (int i = 0; i < 24; i++) send_byte(8'(8'h80 + i), (i == 23), 1'b0);
    idle(3);
    check("t4_commit_ptr6", 64'(Commit_ptr), 64'(6));
    check("t4_wr_addr6", 64'(Wr_addr), 64'(6));
    Rd_ptr = 3'd6;
    push_wr(3'd6, 36'h0_C0C1C2C3);
    push_wr(3'd7, 36'h0_C4C5C6C7);
    push_wr(3'd0, 36'hB_C8C9CACB);
    exp_ev_q.push_back(2'd1);
    for (int i = 0; i < 12; i++) send_byte(8'(8'hC0 + i), (i == 11), 1'b0);
    idle(3);
    check("t4_commit_ptr", 64'(Commit_ptr), 64'(1));
    check("t4_wr_addr", 64'(Wr_addr), 64'(1));

    // Single-byte packets back to back.
    do_reset();
    Rd_ptr = '0;
    max_commit_run = 0;
    push_wr(3'd0, 36'h8_31000000);
    push_wr(3'd1, 36'h8_32000000);
    push_wr(3'd2, 36'h8_33000000);
    push_wr(3'd3, 36'h8_34000000);
    push_wr(3'd4, 36'h8_35000000);
    repeat (5) exp_ev_q.push_back(2'd1);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h31 + i), 1'b1, 1'b0);
    idle(3);
    check("t5_commit_run", 64'(max_commit_run), 64'(5));
    check("t5_commit_ptr", 64'(Commit_ptr), 64'(5));

    // Reset during the 3rd byte of a packet.
    send_byte(8'h41, 0, 0);
    send_byte(8'h42, 0, 0);
    @(negedge Clk);
    Rx_data = 8'h43; Rx_data_en = 1'b1; Rx_data_end = 1'b0;
    Reset = 1'b1;
    #1;
    check("t6_wr_addr", 64'(Wr_addr), 64'(0));
    check("t6_commit_ptr", 64'(Commit_ptr), 64'(0));
    check("t6_wr_data", 64'(Wr_data), 64'(0));
    check("t6_outs", 64'({Wr_en, Pkt_commit, Pkt_drop, Full}), 64'(0));
    check("t6_drop_cnt", 64'(Drop_cnt), 64'(0));
    @(negedge Clk);
    Reset = 1'b0; Rx_data_en = 1'b0;
    push_wr(3'd0, 36'hB_51525354);
    exp_ev_q.push_back(2'd1);
    send_byte(8'h51, 0, 0); send_byte(8'h52, 0, 0);
    send_byte(8'h53, 0, 0); send_byte(8'h54, 1, 0);
    idle(3);
    check("t6_commit_ptr_after", 64'(Commit_ptr), 64'(1));
    check("t6_drop_cnt_after", 64'(Drop_cnt), 64'(0));

    // ---------------- report ----------------
    check("wr_queue_drained", 64'(exp_q.size()), 64'(0));
    check("ev_queue_drained", 64'(exp_ev_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
